// File: rtl/activation_skew_feeder.sv
// activation_skew_feeder: reads an NxN activation tile row by row and skews it diagonally onto the array's west edge
module activation_skew_feeder #(
  parameter int SYSTOLIC_SIZE    = 8,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int ADDR_WIDTH       = $clog2(SYSTOLIC_SIZE)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  output logic [ADDR_WIDTH-1:0]                      mem_rd_addr,
  input  logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  mem_rd_data_flat,
  output logic [SYSTOLIC_SIZE*ACTIVATION_WIDTH-1:0]  act_out_flat,
  output logic [SYSTOLIC_SIZE-1:0]                   act_valid,
  output logic                                       busy,
  output logic                                       done
);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  localparam logic [ADDR_WIDTH-1:0] FEED_LAST  = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(SYSTOLIC_SIZE - 2);
  state_t                state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  feed;
  assign feed        = state == FEED;
  assign mem_rd_addr = feed ? cnt : '0;
  // tile sequencer: N read cycles, N-1 flush cycles, one done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state <= FEED;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        FEED: if (cnt == FEED_LAST) begin
          state <= DRAIN;
          cnt   <= '0;
        end else cnt <= cnt + 1'b1;
        DRAIN: if (cnt == DRAIN_LAST) begin
          state <= DONE;
          cnt   <= '0;
          done  <= 1'b1;
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end
  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_lane
    logic [ACTIVATION_WIDTH-1:0] d [0:i];
    logic [i:0]                  v;
    // lane i is an (i+1)-deep chain; zeros ride with valid=0 so idle lanes never show stale data
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j <= i; j++) d[j] <= '0;
        v <= '0;
      end else begin
        d[0] <= feed ? mem_rd_data_flat[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] : '0;
        v[0] <= feed;
        for (int j = 1; j <= i; j++) begin
          d[j] <= d[j-1];
          v[j] <= v[j-1];
        end
      end
    end
    assign act_out_flat[i*ACTIVATION_WIDTH +: ACTIVATION_WIDTH] = d[i];
    assign act_valid[i] = v[i];
  end
endmodule

// File: tb/tb_activation_skew_feeder.sv
// tb_activation_skew_feeder: directed checks of tile timing, skew, zero rule, reset abort and back-to-back tiles
module tb_activation_skew_feeder;
  localparam int N = 8;
  localparam int W = 8;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [2:0]     mem_rd_addr;
  logic [N*W-1:0] mem_rd_data_flat;
  logic [N*W-1:0] act_out_flat;
  logic [N-1:0]   act_valid;
  logic           busy;
  logic           done;
  logic [W-1:0]   mem [N][N];
  logic [N-1:0]   cap_v [17];
  logic [N*W-1:0] cap_d [17];
  int checks = 0;
  int errors = 0;
  typedef struct {int c; int lane; logic v; logic [7:0] d;} vec_t;
  vec_t tbl [12];

  activation_skew_feeder #(.SYSTOLIC_SIZE(N), .ACTIVATION_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data_flat(mem_rd_data_flat), .act_out_flat(act_out_flat),
    .act_valid(act_valid), .busy(busy), .done(done));

  always #5 clk = ~clk;

  always_comb for (int i = 0; i < N; i++) mem_rd_data_flat[i*W +: W] = mem[mem_rd_addr][i];

  function automatic logic [7:0] expd(input int pat, input int k, input int i);
    return pat == 0 ? 8'((k << 4) | i) : 8'(255 - k*8 - i);
  endfunction

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic load(input int pat);
    for (int k = 0; k < N; k++) for (int i = 0; i < N; i++) mem[k][i] = expd(pat, k, i);
  endtask

  task automatic chk_idle(input string n);
    chk({n, "_addr"}, 64'(mem_rd_addr), 0);
    chk({n, "_act"}, act_out_flat, 0);
    chk({n, "_valid"}, 64'(act_valid), 0);
    chk({n, "_busy"}, 64'(busy), 0);
    chk({n, "_done"}, 64'(done), 0);
  endtask

  // caller has start=1 ahead of the posedge that enters FEED; samples cycles 0..16
  task automatic check_tile(input int pat, input bit hold, input bit cap);
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk($sformatf("addr c%0d", c), 64'(mem_rd_addr), c < 8 ? c : 0);
      chk($sformatf("busy c%0d", c), 64'(busy), 64'(c <= 15));
      chk($sformatf("done c%0d", c), 64'(done), 64'(c == 15));
      for (int i = 0; i < N; i++) begin
        int ev;
        ev = (c >= i + 1 && c <= i + N) ? 1 : 0;
        chk($sformatf("lane%0d_valid c%0d", i, c), 64'(act_valid[i]), 64'(ev));
        chk($sformatf("lane%0d_data c%0d", i, c), 64'(act_out_flat[i*W +: W]),
            ev != 0 ? 64'(expd(pat, c - 1 - i, i)) : 0);
      end
      if (cap) begin
        cap_v[c] = act_valid;
        cap_d[c] = act_out_flat;
      end
      if (!hold) start = 1'b0;
    end
  endtask

  initial begin
    tbl[0]  = '{1, 0, 1'b1, 8'h00};
    tbl[1]  = '{8, 0, 1'b1, 8'h70};
    tbl[2]  = '{9, 0, 1'b0, 8'h00};
    tbl[3]  = '{8, 7, 1'b1, 8'h07};
    tbl[4]  = '{15, 7, 1'b1, 8'h77};
    tbl[5]  = '{7, 7, 1'b0, 8'h00};
    tbl[6]  = '{4, 3, 1'b1, 8'h03};
    tbl[7]  = '{11, 3, 1'b1, 8'h73};
    tbl[8]  = '{3, 3, 1'b0, 8'h00};
    tbl[9]  = '{12, 3, 1'b0, 8'h00};
    tbl[10] = '{5, 2, 1'b1, 8'h22};
    tbl[11] = '{0, 0, 1'b0, 8'h00};
    load(0);
    #12;
    chk_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle("post_reset");
    start = 1'b1;
    check_tile(0, 1'b0, 1'b1);
    for (int t = 0; t < 12; t++) begin
      chk($sformatf("tbl%0d_valid", t), 64'(cap_v[tbl[t].c][tbl[t].lane]), 64'(tbl[t].v));
      chk($sformatf("tbl%0d_data", t), 64'(cap_d[tbl[t].c][tbl[t].lane*W +: W]), 64'(tbl[t].d));
    end
    start = 1'b1;
    for (int t = 0; t < 3; t++) check_tile(0, 1'b1, 1'b0);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("after_hold");
    start = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("mid_busy", 64'(busy), 1);
    #2 rst_n = 1'b0;
    #1 chk_idle("abort");
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c % 5 == 0) chk_idle($sformatf("residual%0d", c));
    end
    start = 1'b1;
    check_tile(0, 1'b0, 1'b0);
    load(1);
    start = 1'b1;
    check_tile(1, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
